// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX framer and the TX side.
//   uart_state_e : receive FSM states
//   DATA_BITS    : payload bits per frame
//   div_calc     : clock-to-oversample-tick divider value
//   maj3         : 2-of-3 majority vote used for bit sampling
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Integer-truncated divider; never below 1 so the tick still advances.
    function automatic int div_calc(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses o_tick for one
// clock while the count sits at DIV-1. i_clr restarts the count at 0 so the
// tick phase can be aligned to a start edge.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous restart of the divider
//   o_tick  : 1-clock tick every DIV clocks
module uart_os_tick #(
    parameter int DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Divider counter with clear and wrap at DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// Oversampling 8N1 UART receiver front end (LSB first).
// Synchronises rx, validates the start bit, majority-votes each bit from
// three mid-bit samples, checks the stop bit and presents the byte.
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   rx          : serial line, asynchronous, idles high
//   o_data      : last good byte, held until the next good frame
//   o_valid     : 1-cycle strobe, o_data updated
//   o_frame_err : 1-cycle strobe, stop bit sampled low
//   o_busy      : high from start detect until frame done or abandoned
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HM1  = OSW'(H - 1);
    localparam logic [OSW-1:0] OS_H    = OSW'(H);
    localparam logic [OSW-1:0] OS_HP1  = OSW'(H + 1);

    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_rx_s, w_fall, w_tick, w_clr, w_mid, w_vote;
    logic [OSW-1:0]       r_os;
    logic                 r_samp_a, r_samp_b;
    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 w_shift_en, w_load, w_valid_nxt, w_ferr_nxt;
    logic [7:0]           r_data;
    logic                 r_valid, r_ferr, r_busy;

    assign w_rx_s = r_sync2;
    assign w_fall = r_rx_prev & ~w_rx_s;
    // Third sample is taken live at the decision tick.
    assign w_vote = maj3(r_samp_a, r_samp_b, w_rx_s);
    assign w_mid  = w_tick & (r_os == OS_HP1);

    uart_os_tick #(.DIV(DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    // Two-flop synchroniser plus previous value for falling-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Tick index within the current bit and the two early vote samples.
    // The index runs freely across bits; decisions are all taken at H+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_os     <= {OSW{1'b0}};
            r_samp_a <= 1'b0;
            r_samp_b <= 1'b0;
        end else if (w_clr) begin
            r_os     <= {OSW{1'b0}};
            r_samp_a <= r_samp_a;
            r_samp_b <= r_samp_b;
        end else if (w_tick) begin
            r_os     <= (r_os == OS_LAST) ? {OSW{1'b0}} : r_os + OSW'(1);
            r_samp_a <= (r_os == OS_HM1) ? w_rx_s : r_samp_a;
            r_samp_b <= (r_os == OS_H)   ? w_rx_s : r_samp_b;
        end else begin
            r_os     <= r_os;
            r_samp_a <= r_samp_a;
            r_samp_b <= r_samp_b;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_mid) begin
                    w_state_nxt = w_vote ? IDLE : DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_mid) begin
                    w_shift_en  = 1'b1;
                    w_state_nxt = (r_bit_idx == 3'd7) ? STOP : DATA;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            STOP: begin
                if (w_mid && w_vote) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_mid) begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = BREAK;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = BREAK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register (LSB first) and bit index; index restarts on each start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= {DATA_BITS{1'b0}};
            r_bit_idx <= 3'd0;
        end else if (w_clr) begin
            r_shift   <= r_shift;
            r_bit_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
        end else begin
            r_shift   <= r_shift;
            r_bit_idx <= r_bit_idx;
        end
    end

    // Registered outputs: held byte, strobes and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_data  <= w_load ? r_shift : r_data;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_busy      = r_busy;

endmodule
